// File: rtl/spi_reg_master.sv
// spi_reg_master
// SPI master with a request arbiter for the register-slave bus. NREQ on-chip
// requesters share one SPI link. Each grant runs one transaction: an 8-bit
// command byte {r_w, adr[6:0]} followed by NBIT data bits, MSB first.
//
// Optional feature macro: SPI_MASTER_RR_EN
//   defined   : round-robin arbitration; the search starts after the last grant
//   undefined : fixed priority; the lowest index wins
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   req    in   [NREQ]       level request per requester, held until its ack
//   rw     in   [NREQ]       direction per requester (1 = write, 0 = read)
//   adr    in   [7*NREQ]     register address, requester i at [7i+6:7i]
//   wdata  in   [NBIT*NREQ]  write data, requester i at [NBIT*i +: NBIT]
//   ack    out  [NREQ]       one-cycle completion pulse to the granted requester
//   rdata  out  [NBIT]       read data, updated in the ack cycle of reads
//   busy   out  high from grant until the end of the inter-transaction gap
//   cs     out  chip select, active low
//   sclk   out  serial clock, idle low
//   mosi   out  master data out
//   miso   in   slave data in (wired bus)
//
// state  | meaning
// IDLE   | cs high, waiting for any req
// SETUP  | cs low, command MSB on mosi, HALF cycles before the first sclk rise
// SHIFT  | 8+NBIT sclk periods (HALF high, HALF low)
// HOLD   | sclk low for HALF cycles after the last fall, then ack
// GAP    | cs high for CS_GAP cycles before returning to IDLE

module spi_reg_master #(
  parameter int NBIT   = 8,
  parameter int NREQ   = 2,
  parameter int HALF   = 4,
  parameter int CS_GAP = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      rw,
  input  logic [7*NREQ-1:0]    adr,
  input  logic [NBIT*NREQ-1:0] wdata,
  output logic [NREQ-1:0]      ack,
  output logic [NBIT-1:0]      rdata,
  output logic                 busy,
  output logic                 cs,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int W    = 8 + NBIT;
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (HALF > CS_GAP) ? HALF : CS_GAP;
  localparam int CW   = $clog2(CMAX);
  localparam int BW   = $clog2(W);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_cnt;
  // Bits still to be presented on mosi; the current bit lives in mosi itself.
  logic [W-2:0]    tx_sh;
  logic [NBIT-1:0] rx_sh;
  logic [IW-1:0]   win_q;
  logic            rw_q;

  logic [IW-1:0]   win;
  logic            found;
  logic            sel_rw;
  logic [6:0]      sel_adr;
  logic [NBIT-1:0] sel_wdata;

`ifdef SPI_MASTER_RR_EN
  logic [IW-1:0]   ptr;
`endif

  // Arbiter: scan NREQ candidates, starting after the last grant when
  // round-robin is enabled, otherwise from index 0.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef SPI_MASTER_RR_EN
      idx = (int'(ptr) + 1 + k) % NREQ;
`else
      idx = k;
`endif
      if (!found && ((req & (NREQ'(1) << idx)) != '0)) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    sel_rw    = 1'b0;
    sel_adr   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sel_rw    = rw[i];
        sel_adr   = adr[7*i +: 7];
        sel_wdata = wdata[NBIT*i +: NBIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ack     <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      win_q   <= '0;
      rw_q    <= 1'b0;
`ifdef SPI_MASTER_RR_EN
      ptr     <= IW'(NREQ - 1);
`endif
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            state <= ST_SETUP;
            busy  <= 1'b1;
            cs    <= 1'b0;
            cnt   <= CW'(HALF - 1);
            win_q <= win;
            rw_q  <= sel_rw;
            mosi  <= sel_rw;
            // Reads shift zeros during the data phase.
            tx_sh <= {sel_adr, {NBIT{sel_rw}} & sel_wdata};
`ifdef SPI_MASTER_RR_EN
            ptr   <= win;
`endif
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            state   <= ST_SHIFT;
            sclk    <= 1'b1;
            rx_sh   <= {rx_sh[NBIT-2:0], miso};
            bit_cnt <= BW'(W - 1);
            cnt     <= CW'(HALF - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (sclk) begin
            sclk  <= 1'b0;
            mosi  <= tx_sh[W-2];
            tx_sh <= {tx_sh[W-3:0], 1'b0};
            cnt   <= CW'(HALF - 1);
          end else if (bit_cnt == '0) begin
            state <= ST_HOLD;
            cnt   <= CW'(HALF - 1);
          end else begin
            // miso is captured on every rise; the command-phase bits fall off
            // the top, leaving exactly the NBIT data bits.
            sclk    <= 1'b1;
            rx_sh   <= {rx_sh[NBIT-2:0], miso};
            bit_cnt <= bit_cnt - 1'b1;
            cnt     <= CW'(HALF - 1);
          end
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            state <= ST_GAP;
            cs    <= 1'b1;
            mosi  <= 1'b0;
            ack   <= NREQ'(1) << win_q;
            if (!rw_q) rdata <= rx_sh;
            cnt   <= CW'(CS_GAP - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
